wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
//  Round-robin Wishbone B4 (classic) arbiter. Shares one slave-side bus among N_MASTERS masters.
//  Sits between CPU/DMA masters and a wbInterconnect slave port or a single shared peripheral.
//  The grant is held for a whole bus cycle (mcyc_i high), so a master's multi-beat cycle is never split.
// PARAMETERS
//  N_MASTERS       2    number of requesting masters (1..16)
//  TIMEOUT_CYCLES  255  stalled-strobe cycles before forced release (only with WB_ARB_TIMEOUT_EN)
// PORTS
//  clk_i    in   1            clock; all logic on the rising edge
//  rst_i    in   1            synchronous reset, active-high
//  madr_i   in   32 [N]       per-master address
//  mdat_i   in   32 [N]       per-master write data
//  mdat_o   out  32 [N]       read data; sdat_i is broadcast to all masters
//  mwe_i    in   1  [N]       per-master write enable
//  msel_i   in   4  [N]       per-master byte select
//  mstb_i   in   1  [N]       per-master strobe
//  mcyc_i   in   1  [N]       per-master cycle / bus request
//  mack_o   out  1  [N]       ack; only the granted master sees sack_i
//  merr_o   out  1  [N]       timeout error pulse (tied 0 without WB_ARB_TIMEOUT_EN)
//  sadr_o/sdat_o/swe_o/ssel_o/sstb_o/scyc_o  out  32/32/1/4/1/1  muxed slave-side bus
//  sdat_i   in   32           slave read data
//  sack_i   in   1            slave ack
//  grant_o  out  N            one-hot current grant; all zero when idle
// BEHAVIOUR
//  - Reset: state IDLE, grant_o=0, rr_ptr=0, timeout counter=0.
//    scyc_o, sstb_o, swe_o, mack_o and merr_o are 0 and sadr_o/sdat_o/ssel_o are 0 while granted-none.
//    scyc_o/sstb_o are also gated combinationally by !rst_i, so a reset mid-cycle ends the slave cycle at once.
//  - FSM states: IDLE, BUSY, and RELEASE (RELEASE only with the macro).
//  - IDLE: if any mcyc_i is high, pick the first requester at or after rr_ptr (cyclic order).
//    Register it into grant_o and go to BUSY. Latency is 1 cycle from request to scyc_o.
//  - BUSY: slave outputs = granted master's inputs (combinational mux on the registered grant).
//    mack_o[g] = sack_i. Every other mack_o is 0.
//  - BUSY, granted mcyc_i low: scyc_o drops in that same cycle (forwarded).
//    Next edge: go to IDLE, grant_o=0, rr_ptr=(g+1) mod N_MASTERS.
//  - There is always >=1 idle cycle between grants. A master re-requesting immediately ranks last behind other requesters.
//  - An ack arriving in the same cycle as the mcyc_i drop is still routed to g.
//  - Requests from non-granted masters are ignored while BUSY; they get no ack and no data-path effect.
//  - N_MASTERS=1: the pointer stays 0. The same master is granted again after each idle cycle.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//   - The counter increments on each cycle where sstb_o && !sack_i.
//   - The counter clears on sack_i or on leaving BUSY.
//   - When the counter reaches TIMEOUT_CYCLES-1 with sack_i still low: merr_o[g] pulses 1 cycle,
//     the FSM goes to RELEASE (scyc_o=0, sstb_o=0), then IDLE, and rr_ptr advances.
//   - The master must drop mcyc_i. The arbiter does not re-grant it until it has seen it low.
//  WB_ARB_TIMEOUT_EN undefined: no counter and no RELEASE state; merr_o is constant 0.
//   A hung slave holds the grant forever.
// STRUCTURE
//  - Package wb_pkg: WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4, and the typedef arb_state_t {IDLE, BUSY, RELEASE}.
//  - Sub-module rr_pick: combinational; inputs req[N] and ptr; outputs one-hot gnt[N] and valid.
//    It rotates, applies a priority-encode, and un-rotates.
// TESTING
//  1. Reset: rst_i=1 during an active grant -> next cycle grant_o=0, scyc_o=0. Both masters then request -> m0 granted.
//  2. Simultaneous requests: m0 and m1 hold mcyc_i continuously, each doing one 1-beat cycle ->
//     grants alternate m0,m1,m0, with 1 idle cycle between grants.
//  3. Burst hold: m1 granted; 3 beats with sack_i on each; m0 requests meanwhile ->
//     m0 gets no ack until m1 drops mcyc_i; m0 is granted 2 cycles after the drop.
//  4. Routing: m1 writes adr 0x0000_1000, dat 0xDEAD_BEEF, sel 0xF -> slave sees these exact values.
//     The slave returns sdat_i=0x1234_5678 with ack -> mack_o[1]=1, mack_o[0]=0.
//  5. Timeout (macro on, TIMEOUT_CYCLES=8): slave never acks ->
//     merr_o[g]=1 for one cycle at strobe cycle 8, scyc_o=0 the next cycle, the other master is granted next.
//  6. Macro off, same stimulus as test 5 -> merr_o stays 0 and the grant is held for 100 cycles.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone widths and arbiter state encoding for wb_rr_arbiter.
package wb_pkg;

    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. It rotates the request vector so that
// index ptr becomes bit 0, keeps the lowest set bit, then rotates the result back.
module rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             valid
);

    logic [N-1:0] rot_req;
    logic [N-1:0] rot_gnt;

    // Rotate, isolate the lowest requester, un-rotate.
    always_comb begin
        rot_req = N'({req, req} >> ptr);
        rot_gnt = rot_req & (~rot_req + N'(1));
        gnt     = N'(({rot_gnt, rot_gnt} << ptr) >> N);
        valid   = |req;
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone B4 classic arbiter. A grant is held for the
// whole bus cycle (mcyc_i high) and there is always one idle cycle between grants.
// Optional feature macro: WB_ARB_TIMEOUT_EN (stalled-strobe timeout with forced release).
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned N_MASTERS      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_MASTERS*WB_ADR_W-1:0]   madr_i,
    input  logic [N_MASTERS*WB_DAT_W-1:0]   mdat_i,
    output logic [N_MASTERS*WB_DAT_W-1:0]   mdat_o,
    input  logic [N_MASTERS-1:0]            mwe_i,
    input  logic [N_MASTERS*WB_SEL_W-1:0]   msel_i,
    input  logic [N_MASTERS-1:0]            mstb_i,
    input  logic [N_MASTERS-1:0]            mcyc_i,
    output logic [N_MASTERS-1:0]            mack_o,
    output logic [N_MASTERS-1:0]            merr_o,
    output logic [WB_ADR_W-1:0]             sadr_o,
    output logic [WB_DAT_W-1:0]             sdat_o,
    output logic                            swe_o,
    output logic [WB_SEL_W-1:0]             ssel_o,
    output logic                            sstb_o,
    output logic                            scyc_o,
    input  logic [WB_DAT_W-1:0]             sdat_i,
    input  logic                            sack_i,
    output logic [N_MASTERS-1:0]            grant_o
);

    localparam int unsigned PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    if (N_MASTERS < 1 || N_MASTERS > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("wb_rr_arbiter: unsupported N_MASTERS or TIMEOUT_CYCLES");
    end

    arb_state_t             state_q, state_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       next_ptr;
    logic [N_MASTERS-1:0]   req_vec;
    logic [N_MASTERS-1:0]   pick_gnt;
    logic                   pick_valid;
    logic                   busy;
    logic                   gnt_cyc;
    logic                   gnt_stb;

    rr_pick #(
        .N     (N_MASTERS),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req_vec),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    assign busy    = (state_q == BUSY);
    assign grant_o = grant_q;
    assign mdat_o  = {N_MASTERS{sdat_i}};

    // Slave-side mux driven by the registered one-hot grant (all zero when none granted).
    always_comb begin
        sadr_o  = '0;
        sdat_o  = '0;
        ssel_o  = '0;
        swe_o   = 1'b0;
        gnt_cyc = 1'b0;
        gnt_stb = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_q[i]) begin
                sadr_o  = sadr_o | madr_i[i*WB_ADR_W +: WB_ADR_W];
                sdat_o  = sdat_o | mdat_i[i*WB_DAT_W +: WB_DAT_W];
                ssel_o  = ssel_o | msel_i[i*WB_SEL_W +: WB_SEL_W];
                swe_o   = swe_o | mwe_i[i];
                gnt_cyc = gnt_cyc | mcyc_i[i];
                gnt_stb = gnt_stb | mstb_i[i];
            end
        end
    end

    // Cycle/strobe are forwarded from the granted master and cut immediately by reset.
    always_comb begin
        scyc_o = busy & gnt_cyc & ~rst_i;
        sstb_o = busy & gnt_cyc & gnt_stb & ~rst_i;
        mack_o = (busy && !rst_i) ? (grant_q & {N_MASTERS{sack_i}}) : '0;
    end

    // Pointer value one past the current grant, wrapping at N_MASTERS.
    always_comb begin
        next_ptr = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_q[i]) begin
                next_ptr = (i == int'(N_MASTERS) - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [N_MASTERS-1:0]   block_q, block_d;
    logic                   timeout_hit;

    // A master that timed out stays masked until it has dropped mcyc_i once.
    assign req_vec     = mcyc_i & ~block_q;
    assign timeout_hit = sstb_o & ~sack_i & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign merr_o      = timeout_hit ? grant_q : '0;
`else
    assign req_vec = mcyc_i;
    assign merr_o  = '0;
`endif

    // Next-state logic: grant on request, hold for the bus cycle, release on mcyc_i drop.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
`ifdef WB_ARB_TIMEOUT_EN
        block_d = block_q & mcyc_i;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_gnt;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!gnt_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = RELEASE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    block_d = block_d | grant_q;
                end
            end
            RELEASE: begin
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    // Stall counter: counts unacked strobe cycles, clears on ack or when leaving BUSY.
    always_comb begin
        cnt_d = cnt_q;
        if (!busy || state_d != BUSY || sack_i) begin
            cnt_d = '0;
        end else if (sstb_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Timeout counter and re-grant mask registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            block_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            block_q <= block_d;
        end
    end
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter (N_MASTERS=2, TIMEOUT_CYCLES=8).
module tb_wb_rr_arbiter;

    localparam int unsigned N = 2;

    logic         clk;
    logic         rst;
    logic [63:0]  madr, mdat_m, mdat_o;
    logic [1:0]   mwe, mstb, mcyc, mack, merr, grant;
    logic [7:0]   msel;
    logic [31:0]  sadr, sdat_o, sdat_i;
    logic         swe, sstb, scyc, sack;
    logic [3:0]   ssel;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] cyc;
        logic [1:0] stb;
        logic       ack;
        logic [1:0] exp_grant;
        logic       exp_scyc;
        logic [1:0] exp_mack;
    } vec_t;

    vec_t tbl [18];
    vec_t exp_q [$];

    wb_rr_arbiter #(.N_MASTERS(N), .TIMEOUT_CYCLES(8)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .madr_i  (madr),
        .mdat_i  (mdat_m),
        .mdat_o  (mdat_o),
        .mwe_i   (mwe),
        .msel_i  (msel),
        .mstb_i  (mstb),
        .mcyc_i  (mcyc),
        .mack_o  (mack),
        .merr_o  (merr),
        .sadr_o  (sadr),
        .sdat_o  (sdat_o),
        .swe_o   (swe),
        .ssel_o  (ssel),
        .sstb_o  (sstb),
        .scyc_o  (scyc),
        .sdat_i  (sdat_i),
        .sack_i  (sack),
        .grant_o (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        vec_t e;
        logic [31:0] hi;
        logic [31:0] lo;

        // cyc, stb, ack | grant, scyc, mack
        tbl[0]  = '{2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[1]  = '{2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01};
        tbl[2]  = '{2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00};
        tbl[3]  = '{2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[4]  = '{2'b11, 2'b10, 1'b1, 2'b10, 1'b1, 2'b10};
        tbl[5]  = '{2'b01, 2'b00, 1'b0, 2'b10, 1'b0, 2'b00};
        tbl[6]  = '{2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[7]  = '{2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01};
        tbl[8]  = '{2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00};
        tbl[9]  = '{2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[10] = '{2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 2'b10};
        tbl[11] = '{2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 2'b10};
        tbl[12] = '{2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 2'b10};
        tbl[13] = '{2'b01, 2'b01, 1'b0, 2'b10, 1'b0, 2'b00};
        tbl[14] = '{2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[15] = '{2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 2'b00};
        tbl[16] = '{2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 2'b01};
        tbl[17] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00};

        rst    = 1'b1;
        madr   = {32'hB000_0000, 32'hA000_0000};
        mdat_m = {32'hBBBB_0001, 32'hAAAA_0001};
        mwe    = 2'b00;
        msel   = 8'h00;
        mstb   = 2'b00;
        mcyc   = 2'b00;
        sdat_i = 32'h0;
        sack   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_scyc", 64'(scyc), 64'h0);
        check("rst_sstb", 64'(sstb), 64'h0);
        check("rst_mack", 64'(mack), 64'h0);
        check("rst_merr", 64'(merr), 64'h0);
        check("rst_sadr", 64'(sadr), 64'h0);
        check("rst_swe", 64'(swe), 64'h0);

        // Reset during an active grant
        @(negedge clk); rst = 1'b0; mcyc = 2'b10; mstb = 2'b10;
        #2 check("t1_req_latency", 64'(grant), 64'h0);
        @(negedge clk); #2;
        check("t1_grant_m1", 64'(grant), 64'h2);
        check("t1_scyc_m1", 64'(scyc), 64'h1);
        check("t1_sstb_m1", 64'(sstb), 64'h1);
        @(negedge clk); rst = 1'b1;
        #2;
        check("t1_scyc_gated", 64'(scyc), 64'h0);
        check("t1_sstb_gated", 64'(sstb), 64'h0);
        @(negedge clk); rst = 1'b0; mcyc = 2'b11; mstb = 2'b00;
        #2;
        check("t1_grant_after_rst", 64'(grant), 64'h0);
        check("t1_scyc_after_rst", 64'(scyc), 64'h0);
        @(negedge clk); #2 check("t1_m0_first", 64'(grant), 64'h1);
        @(negedge clk); rst = 1'b1; mcyc = 2'b00;
        @(negedge clk); rst = 1'b0;

        // Alternation and burst hold, table-driven with a scoreboard queue
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            mcyc = tbl[i].cyc;
            mstb = tbl[i].stb;
            sack = tbl[i].ack;
            exp_q.push_back(tbl[i]);
            #2;
            e = exp_q.pop_front();
            check($sformatf("row%0d_grant", i), 64'(grant), 64'(e.exp_grant));
            check($sformatf("row%0d_scyc", i), 64'(scyc), 64'(e.exp_scyc));
            check($sformatf("row%0d_mack", i), 64'(mack), 64'(e.exp_mack));
            check($sformatf("row%0d_merr", i), 64'(merr), 64'h0);
        end

        // Routing: m1 write, slave read data returned with ack (pointer now at m1)
        @(negedge clk);
        sack   = 1'b0;
        mcyc   = 2'b11;
        mstb   = 2'b11;
        mwe    = 2'b10;
        madr   = {32'h0000_1000, 32'hAAAA_0000};
        mdat_m = {32'hDEAD_BEEF, 32'h5555_5555};
        msel   = 8'hF1;
        #2 check("t4_idle", 64'(grant), 64'h0);
        @(negedge clk); sack = 1'b1; sdat_i = 32'h1234_5678;
        #2;
        hi = mdat_o[63:32];
        lo = mdat_o[31:0];
        check("t4_grant", 64'(grant), 64'h2);
        check("t4_sadr", 64'(sadr), 64'h0000_1000);
        check("t4_sdat", 64'(sdat_o), 64'hDEAD_BEEF);
        check("t4_ssel", 64'(ssel), 64'hF);
        check("t4_swe", 64'(swe), 64'h1);
        check("t4_sstb", 64'(sstb), 64'h1);
        check("t4_mack", 64'(mack), 64'h2);
        check("t4_mdat1", 64'(hi), 64'h1234_5678);
        check("t4_mdat0", 64'(lo), 64'h1234_5678);
        @(negedge clk); mcyc = 2'b00; mstb = 2'b00; sack = 1'b0; mwe = 2'b00;

        // Hung slave: m0 granted, never acked
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; mcyc = 2'b11; mstb = 2'b01;
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); #2;
            check($sformatf("t5_scyc_k%0d", k), 64'(scyc), 64'h1);
            check($sformatf("t5_merr_k%0d", k), 64'(merr), (k == 8) ? 64'h1 : 64'h0);
        end
        @(negedge clk); mstb = 2'b11;
        #2;
        check("t5_rel_scyc", 64'(scyc), 64'h0);
        check("t5_rel_sstb", 64'(sstb), 64'h0);
        check("t5_rel_merr", 64'(merr), 64'h0);
        check("t5_rel_grant", 64'(grant), 64'h0);
        @(negedge clk); #2 check("t5_idle_grant", 64'(grant), 64'h0);
        @(negedge clk); #2;
        check("t5_m1_grant", 64'(grant), 64'h2);
        check("t5_m1_scyc", 64'(scyc), 64'h1);
        @(negedge clk); mcyc = 2'b01;
        #2 check("t5_m1_drop_scyc", 64'(scyc), 64'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #2 check($sformatf("t5_m0_blocked%0d", k), 64'(grant), 64'h0);
        end
        @(negedge clk); mcyc = 2'b00;
        #2 check("t5_m0_low", 64'(grant), 64'h0);
        @(negedge clk); mcyc = 2'b01;
        #2 check("t5_m0_rereq", 64'(grant), 64'h0);
        @(negedge clk); #2 check("t5_m0_regrant", 64'(grant), 64'h1);
`else
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk); #2;
            check($sformatf("t6_grant_k%0d", k), 64'(grant), 64'h1);
            check($sformatf("t6_scyc_k%0d", k), 64'(scyc), 64'h1);
            check($sformatf("t6_merr_k%0d", k), 64'(merr), 64'h0);
        end
`endif
        @(negedge clk); mcyc = 2'b00; mstb = 2'b00;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
